// File: rtl/gelato_fetch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : gelato_fetch_scheduler
//  Function : Per-cycle warp selector feeding the instruction fetch stage.
//             Picks one eligible warp (valid PC entry, nothing in flight),
//             registers its PC / split index into a valid/ready fetch
//             request, and marks the warp pending until decode releases it.
//  Options  : GELATO_FETCH_SKD_GTO_EN - greedy-then-oldest arbitration
//             (re-grant the last warp if still eligible); default build is
//             pure round-robin.
//  Revision : 1.0 - initial release
// ============================================================================
module gelato_fetch_scheduler #(
   parameter int WARP_NUM        = 4,
   parameter int PC_WIDTH        = 32,
   parameter int SPLIT_NUM_WIDTH = 2,
   parameter int WARP_NUM_WIDTH  = $clog2(WARP_NUM)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                rdy,
   input  logic [WARP_NUM-1:0]                 pc_valid,
   input  logic [WARP_NUM*PC_WIDTH-1:0]        pc,
   input  logic [WARP_NUM*SPLIT_NUM_WIDTH-1:0] pc_split_num,
   output logic                                fetch_valid,
   input  logic                                fetch_ready,
   output logic [WARP_NUM_WIDTH-1:0]           fetch_warp_num,
   output logic [PC_WIDTH-1:0]                 fetch_pc,
   output logic [SPLIT_NUM_WIDTH-1:0]          fetch_split_num,
   input  logic                                release_valid,
   input  logic [WARP_NUM_WIDTH-1:0]           release_warp_num,
   output logic [WARP_NUM-1:0]                 pending,
   output logic [15:0]                         stall_cnt
);

   localparam logic [WARP_NUM_WIDTH-1:0] c_LAST_WARP = WARP_NUM_WIDTH'(WARP_NUM - 1);
   localparam logic [15:0]               c_STALL_MAX = 16'hFFFF;

   // Registered state
   logic                       r_fetch_valid;
   logic [WARP_NUM_WIDTH-1:0]  r_fetch_warp_num;
   logic [PC_WIDTH-1:0]        r_fetch_pc;
   logic [SPLIT_NUM_WIDTH-1:0] r_fetch_split_num;
   logic [WARP_NUM-1:0]        r_pending;
   logic [15:0]                r_stall_cnt;
   logic [WARP_NUM_WIDTH-1:0]  r_last_grant;

   // Combinational decisions
   logic [WARP_NUM-1:0]        w_eligible;
   logic                       w_can_load;
   logic                       w_found;
   logic [WARP_NUM_WIDTH-1:0]  w_winner;
   logic [WARP_NUM_WIDTH-1:0]  w_idx;
   logic                       w_grant;
   logic                       w_release;
   logic [WARP_NUM-1:0]        w_grant_mask;
   logic [WARP_NUM-1:0]        w_release_mask;
   logic [PC_WIDTH-1:0]        w_win_pc;
   logic [SPLIT_NUM_WIDTH-1:0] w_win_split;
   logic                       w_stall;

   assign w_eligible = pc_valid & ~r_pending;
   // The output register is free when empty or being drained this cycle.
   assign w_can_load = rdy & (~r_fetch_valid | fetch_ready);
   assign w_grant    = w_can_load & w_found;
   assign w_release  = rdy & release_valid;
   assign w_stall    = rdy & r_fetch_valid & ~fetch_ready;

   // Arbitration: rotating search starting one past the last grant; the last
   // grant itself is examined last (k == WARP_NUM wraps back onto it).
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_last_grant;
      w_idx    = '0;
`ifdef GELATO_FETCH_SKD_GTO_EN
      if (w_eligible[r_last_grant]) begin
         w_found  = 1'b1;
         w_winner = r_last_grant;
      end
`endif
      for (int k = 1; k <= WARP_NUM; k++) begin
         w_idx = r_last_grant + WARP_NUM_WIDTH'(k);
         if (!w_found && w_eligible[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   // Select the winner's PC-table fields (only captured on a grant).
   always_comb begin
      w_win_pc    = pc[int'(w_winner)*PC_WIDTH +: PC_WIDTH];
      w_win_split = pc_split_num[int'(w_winner)*SPLIT_NUM_WIDTH +: SPLIT_NUM_WIDTH];
   end

   // One-hot masks for setting / clearing per-warp pending flags.
   generate
      for (genvar i = 0; i < WARP_NUM; i++) begin : g_mask
         assign w_grant_mask[i]   = w_grant   & (w_winner         == WARP_NUM_WIDTH'(i));
         assign w_release_mask[i] = w_release & (release_warp_num == WARP_NUM_WIDTH'(i));
      end
   endgenerate

   // Fetch request register: load on grant, drop valid when loading with no
   // eligible warp, otherwise hold (covers backpressure and rdy = 0).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_valid     <= 1'b0;
         r_fetch_warp_num  <= '0;
         r_fetch_pc        <= '0;
         r_fetch_split_num <= '0;
         r_last_grant      <= c_LAST_WARP;
      end else if (w_can_load) begin
         r_fetch_valid <= w_found;
         if (w_found) begin
            r_fetch_warp_num  <= w_winner;
            r_fetch_pc        <= w_win_pc;
            r_fetch_split_num <= w_win_split;
            r_last_grant      <= w_winner;
         end
      end
   end

   // Pending flags: a grant and a release never target the same warp, so the
   // set and clear masks can be combined without priority concerns.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~w_release_mask) | w_grant_mask;
      end
   end

   // Saturating backpressure counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != c_STALL_MAX)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign fetch_valid     = r_fetch_valid;
   assign fetch_warp_num  = r_fetch_warp_num;
   assign fetch_pc        = r_fetch_pc;
   assign fetch_split_num = r_fetch_split_num;
   assign pending         = r_pending;
   assign stall_cnt       = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gelato_fetch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gelato_fetch_scheduler
//  Function : Directed self-checking bench for gelato_fetch_scheduler
//             (WARP_NUM=4, PC_WIDTH=32, SPLIT_NUM_WIDTH=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gelato_fetch_scheduler;

   logic         clk = 1'b0;
   logic         rst;
   logic         rdy;
   logic [3:0]   pc_valid;
   logic [127:0] pc;
   logic [7:0]   pc_split_num;
   logic         fetch_valid;
   logic         fetch_ready;
   logic [1:0]   fetch_warp_num;
   logic [31:0]  fetch_pc;
   logic [1:0]   fetch_split_num;
   logic         release_valid;
   logic [1:0]   release_warp_num;
   logic [3:0]   pending;
   logic [15:0]  stall_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   gelato_fetch_scheduler #(
      .WARP_NUM        (4),
      .PC_WIDTH        (32),
      .SPLIT_NUM_WIDTH (2)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .rdy              (rdy),
      .pc_valid         (pc_valid),
      .pc               (pc),
      .pc_split_num     (pc_split_num),
      .fetch_valid      (fetch_valid),
      .fetch_ready      (fetch_ready),
      .fetch_warp_num   (fetch_warp_num),
      .fetch_pc         (fetch_pc),
      .fetch_split_num  (fetch_split_num),
      .release_valid    (release_valid),
      .release_warp_num (release_warp_num),
      .pending          (pending),
      .stall_cnt        (stall_cnt)
   );

   always #5 clk = ~clk;

   // Inputs are driven and outputs sampled on the falling edge.
   task automatic do_reset();
      rst              = 1'b1;
      rdy              = 1'b1;
      pc_valid         = 4'b0000;
      pc               = '0;
      pc_split_num     = '0;
      fetch_ready      = 1'b0;
      release_valid    = 1'b0;
      release_warp_num = 2'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", fetch_valid); end
      n_cmp++; if (fetch_warp_num !== 2'd0) begin n_bad++; $display("FAIL reset_warp got %0d want 0", fetch_warp_num); end
      n_cmp++; if (fetch_pc !== 32'd0) begin n_bad++; $display("FAIL reset_pc got %h want 0", fetch_pc); end
      n_cmp++; if (fetch_split_num !== 2'd0) begin n_bad++; $display("FAIL reset_split got %0d want 0", fetch_split_num); end
      n_cmp++; if (pending !== 4'b0000) begin n_bad++; $display("FAIL reset_pending got %b want 0000", pending); end
      n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
      // Nothing valid: the register loads empty.
      @(negedge clk);
      n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid got %0b want 0", fetch_valid); end
   endtask

   // All warps valid, each released the cycle it is presented: 0,1,2,3,0.
   task automatic test_round_robin();
      logic [1:0]  exp_w;
      logic [31:0] exp_pc;
      do_reset();
      pc_valid     = 4'b1111;
      pc           = {32'h0000_100C, 32'h0000_1008, 32'h0000_1004, 32'h0000_1000};
      pc_split_num = 8'b00_01_10_11;
      fetch_ready  = 1'b1;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         exp_w  = 2'(s % 4);
         exp_pc = 32'h0000_1000 + 32'(exp_w) * 32'd4;
         n_cmp++; if (fetch_valid !== 1'b1) begin n_bad++; $display("FAIL rr_valid[%0d] got %0b want 1", s, fetch_valid); end
         n_cmp++; if (fetch_warp_num !== exp_w) begin n_bad++; $display("FAIL rr_warp[%0d] got %0d want %0d", s, fetch_warp_num, exp_w); end
         n_cmp++; if (fetch_pc !== exp_pc) begin n_bad++; $display("FAIL rr_pc[%0d] got %h want %h", s, fetch_pc, exp_pc); end
         n_cmp++; if (fetch_split_num !== 2'(3 - exp_w)) begin n_bad++; $display("FAIL rr_split[%0d] got %0d want %0d", s, fetch_split_num, 2'(3 - exp_w)); end
         release_valid    = 1'b1;
         release_warp_num = exp_w;
      end
      release_valid = 1'b0;
   endtask

   // Backpressure holds the request; PC-table changes are not seen.
   task automatic test_hold();
      do_reset();
      pc_valid       = 4'b0100;
      pc[2*32 +: 32] = 32'h0000_0100;
      pc[3*32 +: 32] = 32'h0000_0300;
      fetch_ready    = 1'b0;
      @(negedge clk);
      n_cmp++; if (fetch_valid !== 1'b1 || fetch_warp_num !== 2'd2) begin n_bad++; $display("FAIL hold_grant got v=%0b w=%0d want v=1 w=2", fetch_valid, fetch_warp_num); end
      n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL hold_stall0 got %0d want 0", stall_cnt); end
      pc[2*32 +: 32] = 32'h0000_0200;
      pc_valid       = 4'b1111;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         n_cmp++; if (fetch_valid !== 1'b1 || fetch_warp_num !== 2'd2 || fetch_pc !== 32'h0000_0100) begin
            n_bad++; $display("FAIL hold_out[%0d] got v=%0b w=%0d pc=%h want v=1 w=2 pc=00000100", k, fetch_valid, fetch_warp_num, fetch_pc); end
         n_cmp++; if (stall_cnt !== 16'(k)) begin n_bad++; $display("FAIL hold_stall[%0d] got %0d want %0d", k, stall_cnt, k); end
      end
      n_cmp++; if (pending !== 4'b0100) begin n_bad++; $display("FAIL hold_pending got %b want 0100", pending); end
      fetch_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (fetch_warp_num !== 2'd3 || fetch_pc !== 32'h0000_0300) begin n_bad++; $display("FAIL hold_next got w=%0d pc=%h want w=3 pc=00000300", fetch_warp_num, fetch_pc); end
      n_cmp++; if (stall_cnt !== 16'd5) begin n_bad++; $display("FAIL hold_stall_end got %0d want 5", stall_cnt); end
   endtask

   // Grant to warp 3 and release of warp 1 in the same cycle.
   task automatic test_grant_release();
      do_reset();
      pc_valid    = 4'b0010;
      fetch_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (pending !== 4'b0010 || fetch_warp_num !== 2'd1) begin n_bad++; $display("FAIL gr_first got p=%b w=%0d want p=0010 w=1", pending, fetch_warp_num); end
      pc_valid         = 4'b1010;
      release_valid    = 1'b1;
      release_warp_num = 2'd1;
      @(negedge clk);
      release_valid = 1'b0;
      n_cmp++; if (pending !== 4'b1000) begin n_bad++; $display("FAIL gr_pending got %b want 1000", pending); end
      n_cmp++; if (fetch_warp_num !== 2'd3) begin n_bad++; $display("FAIL gr_warp got %0d want 3", fetch_warp_num); end
      @(negedge clk);
      n_cmp++; if (fetch_valid !== 1'b1 || fetch_warp_num !== 2'd1 || pending !== 4'b1010) begin
         n_bad++; $display("FAIL gr_regrant got v=%0b w=%0d p=%b want v=1 w=1 p=1010", fetch_valid, fetch_warp_num, pending); end
   endtask

   // Single warp with delayed release: one request, idle, then re-grant.
   task automatic test_single_warp();
      do_reset();
      pc_valid    = 4'b0001;
      fetch_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (fetch_valid !== 1'b1 || fetch_warp_num !== 2'd0) begin n_bad++; $display("FAIL sw_grant got v=%0b w=%0d want v=1 w=0", fetch_valid, fetch_warp_num); end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL sw_idle[%0d] got %0b want 0", k, fetch_valid); end
      end
      release_valid    = 1'b1;
      release_warp_num = 2'd0;
      @(negedge clk);
      release_valid = 1'b0;
      n_cmp++; if (fetch_valid !== 1'b0 || pending !== 4'b0000) begin n_bad++; $display("FAIL sw_release got v=%0b p=%b want v=0 p=0000", fetch_valid, pending); end
      @(negedge clk);
      n_cmp++; if (fetch_valid !== 1'b1 || fetch_warp_num !== 2'd0) begin n_bad++; $display("FAIL sw_regrant got v=%0b w=%0d want v=1 w=0", fetch_valid, fetch_warp_num); end
   endtask

   // rdy low freezes everything, including a pulsed release.
   task automatic test_rdy_low();
      do_reset();
      pc_valid       = 4'b0001;
      pc[0 +: 32]    = 32'h0000_0A00;
      pc[1*32 +: 32] = 32'h0000_0B00;
      fetch_ready    = 1'b1;
      @(negedge clk);
      rdy              = 1'b0;
      pc_valid         = 4'b1111;
      release_valid    = 1'b1;
      release_warp_num = 2'd0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         release_valid = 1'b0;
         n_cmp++; if (fetch_valid !== 1'b1 || fetch_warp_num !== 2'd0 || fetch_pc !== 32'h0000_0A00) begin
            n_bad++; $display("FAIL rdy_out[%0d] got v=%0b w=%0d pc=%h want v=1 w=0 pc=00000a00", k, fetch_valid, fetch_warp_num, fetch_pc); end
         n_cmp++; if (pending !== 4'b0001) begin n_bad++; $display("FAIL rdy_pending[%0d] got %b want 0001", k, pending); end
      end
      rdy = 1'b1;
      @(negedge clk);
      n_cmp++; if (fetch_warp_num !== 2'd1 || pending !== 4'b0011) begin n_bad++; $display("FAIL rdy_resume got w=%0d p=%b want w=1 p=0011", fetch_warp_num, pending); end
   endtask

   // Last grant released while its request is held: only greedy re-picks it.
   task automatic test_arbitration_mode();
      logic [1:0] exp_w;
`ifdef GELATO_FETCH_SKD_GTO_EN
      exp_w = 2'd0;
`else
      exp_w = 2'd1;
`endif
      do_reset();
      pc_valid    = 4'b0011;
      fetch_ready = 1'b0;
      @(negedge clk);
      release_valid    = 1'b1;
      release_warp_num = 2'd0;
      @(negedge clk);
      release_valid = 1'b0;
      n_cmp++; if (pending !== 4'b0000 || fetch_warp_num !== 2'd0) begin n_bad++; $display("FAIL mode_hold got p=%b w=%0d want p=0000 w=0", pending, fetch_warp_num); end
      fetch_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (fetch_warp_num !== exp_w) begin n_bad++; $display("FAIL mode_pick got %0d want %0d", fetch_warp_num, exp_w); end
   endtask

   // Two warps released the cycle after each grant alternate every cycle.
   task automatic test_back_to_back();
      logic [1:0] seq [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
      do_reset();
      pc_valid    = 4'b0011;
      fetch_ready = 1'b1;
      for (int s = 0; s < 4; s++) begin
         @(negedge clk);
         n_cmp++; if (fetch_valid !== 1'b1 || fetch_warp_num !== seq[s]) begin
            n_bad++; $display("FAIL b2b[%0d] got v=%0b w=%0d want v=1 w=%0d", s, fetch_valid, fetch_warp_num, seq[s]); end
         release_valid    = 1'b1;
         release_warp_num = seq[s];
      end
      release_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_hold();
      test_grant_release();
      test_single_warp();
      test_rdy_low();
      test_arbitration_mode();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
